fifo_wr_arbiter: RTL

- Round-robin arbiter that shares the single write port of a FIFO (i_wren/i_data/o_full) among G_NUM_REQ requesters.
- Sits in the FIFO write clock domain, directly in front of the FIFO write side.
- Grants one requester at a time for a burst of up to G_MAX_BURST beats, then rotates priority.
- All beat acceptance is qualified by the FIFO full flag, so no write is ever dropped.

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/rr_picker.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int STATS_W = 16;

  // Index width for a range of n values; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first set request at or above
// i_ptr (wrapping), returned one-hot with an any-request flag.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int G_NUM_REQ = 4,
  parameter int G_PTR_W   = idx_width(G_NUM_REQ)
) (
  input  logic [G_NUM_REQ-1:0] i_req,
  input  logic [G_PTR_W-1:0]   i_ptr,
  output logic [G_NUM_REQ-1:0] o_sel,
  output logic                 o_any
);

  localparam logic [G_PTR_W:0] NUM = (G_PTR_W+1)'(G_NUM_REQ);

  logic [G_PTR_W:0] cand;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    o_sel = '0;
    o_any = 1'b0;
    cand  = '0;
    for (int i = 0; i < G_NUM_REQ; i++) begin
      cand = {1'b0, i_ptr} + (G_PTR_W+1)'(i);
      if (cand >= NUM) cand = cand - NUM;
      if (!o_any && i_req[cand[G_PTR_W-1:0]]) begin
        o_sel[cand[G_PTR_W-1:0]] = 1'b1;
        o_any                    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among G_NUM_REQ
// requesters. Define FIFO_WR_ARB_STATS_EN to add per-requester beat counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int G_WIDTH     = 8,
  parameter int G_NUM_REQ   = 4,
  parameter int G_MAX_BURST = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [G_NUM_REQ-1:0]         i_req,
  input  logic [G_NUM_REQ*G_WIDTH-1:0] i_data,
  input  logic [G_NUM_REQ-1:0]         i_last,
  output logic [G_NUM_REQ-1:0]         o_ack,
  output logic [G_NUM_REQ-1:0]         o_grant,
  output logic                         o_wren,
  output logic [G_WIDTH-1:0]           o_data,
  input  logic                         i_full
`ifdef FIFO_WR_ARB_STATS_EN
  , input  logic                         i_stats_clr
  , output logic [G_NUM_REQ*STATS_W-1:0] o_beat_cnt
`endif
);

  localparam int PW = idx_width(G_NUM_REQ);
  localparam int CW = idx_width(G_MAX_BURST + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(G_NUM_REQ - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(G_MAX_BURST);

  arb_state_e             state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          gidx_q, gidx_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic [G_NUM_REQ-1:0]   grant_q, grant_d;
  logic [G_NUM_REQ-1:0]   pick_sel;
  logic                   pick_any;
  logic [PW-1:0]          pick_idx;
  logic                   wren;
  logic                   burst_end;

  rr_picker #(
    .G_NUM_REQ (G_NUM_REQ),
    .G_PTR_W   (PW)
  ) u_picker (
    .i_req (i_req),
    .i_ptr (ptr_q),
    .o_sel (pick_sel),
    .o_any (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < G_NUM_REQ; i++) begin
      if (pick_sel[i]) pick_idx = PW'(i);
    end
  end

  // The write is suppressed in the cycle reset is sampled.
  always_comb begin
    wren = 1'b0;
    if (state_q == BURST && !i_rst) wren = i_req[gidx_q] & ~i_full;
  end

  // gidx_q is 0 outside a burst, so idle data comes from requester 0.
  assign o_wren  = wren;
  assign o_ack   = grant_q & {G_NUM_REQ{wren}};
  assign o_grant = grant_q;
  assign o_data  = i_data[int'(gidx_q)*G_WIDTH +: G_WIDTH];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    burst_end = 1'b0;
    cnt_inc   = cnt_q + CW'(1);
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BURST;
          grant_d = pick_sel;
          gidx_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (!i_req[gidx_q]) begin
          burst_end = 1'b1;
        end else if (wren) begin
          cnt_d = cnt_inc;
          if (i_last[gidx_q] || cnt_inc == MAX_CNT) burst_end = 1'b1;
        end
        if (burst_end) begin
          state_d = IDLE;
          grant_d = '0;
          gidx_d  = '0;
          cnt_d   = '0;
          ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STATS_W-1:0] beat_cnt_q [G_NUM_REQ];

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < G_NUM_REQ; k++) begin
      if (i_rst || i_stats_clr) begin
        beat_cnt_q[k] <= '0;
      end else if (o_ack[k] && beat_cnt_q[k] != '1) begin
        beat_cnt_q[k] <= beat_cnt_q[k] + STATS_W'(1);
      end
    end
  end

  for (genvar k = 0; k < G_NUM_REQ; k++) begin : g_stats
    assign o_beat_cnt[k*STATS_W +: STATS_W] = beat_cnt_q[k];
  end
`endif

endmodule
